// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}; display pins are active-low.
package sevenseg_pkg;

  localparam int MAX_DIG = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       SEG_ON    = 1'b0;
  localparam logic       AN_ON     = 1'b0;
  localparam logic       AN_OFF    = 1'b1;
  localparam logic       DP_OFF    = 1'b1;

  // Sized for the widest build; narrower builds leave upper bits zero.
  typedef struct packed {
    logic [4*MAX_DIG-1:0] digits;
    logic [MAX_DIG-1:0]   dp;
    logic [MAX_DIG-1:0]   blank;
    logic [MAX_DIG-1:0]   blink_mask;
    logic                 lz_en;
  } disp_set_t;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] on;
    case (h)
      4'h0:    on = 7'h3F;
      4'h1:    on = 7'h06;
      4'h2:    on = 7'h5B;
      4'h3:    on = 7'h4F;
      4'h4:    on = 7'h66;
      4'h5:    on = 7'h6D;
      4'h6:    on = 7'h7D;
      4'h7:    on = 7'h07;
      4'h8:    on = 7'h7F;
      4'h9:    on = 7'h6F;
      4'hA:    on = 7'h77;
      4'hB:    on = 7'h7C;
      4'hC:    on = 7'h39;
      4'hD:    on = 7'h5E;
      4'hE:    on = 7'h79;
      default: on = 7'h71;
    endcase
    return (SEG_ON == 1'b0) ? ~on : on;
  endfunction

endpackage

// File: rtl/sevenseg_dec.sv
// Hex digit to active-low segment pattern, blanked when not enabled.
// One shared instance sits after the digit mux.
module sevenseg_dec
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex_i,
  input  logic       en_i,
  output logic [6:0] seg_o
);

  assign seg_o = en_i ? hex2seg(hex_i) : SEG_BLANK;

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed N_DIG seven-segment scanner with PWM brightness and
// frame-synchronous updates; SEVENSEG_BLINK_EN adds per-digit blinking.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int N_DIG       = 8,
  parameter int REFRESH_DIV = 2**18,
  parameter int BRIGHT_W    = 4,
  parameter int BLINK_W     = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIG-1:0]    digits,
  input  logic [N_DIG-1:0]      dp_in,
  input  logic [N_DIG-1:0]      blank,
  input  logic [N_DIG-1:0]      blink_mask,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic                  upd_pend,
  output logic                  frame,
  output logic [6:0]            seg,
  output logic [N_DIG-1:0]      an,
  output logic                  dp
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIG);
  localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

  logic [SW-1:0]       slot_q;
  logic [IW-1:0]       idx_q;
  logic [BRIGHT_W-1:0] pwm_q;
  logic [BRIGHT_W-1:0] bright_q;
  disp_set_t           pend_q;
  disp_set_t           act_q;
  logic                upd_q;
  logic                frame_q;
  logic [6:0]          seg_q;
  logic [N_DIG-1:0]    an_q;
  logic                dp_q;

  disp_set_t        ld_set;
  logic             tick;
  logic             commit;
  logic [3:0]       idx_w;
  logic [5:0]       hex_base;
  logic [3:0]       cur_hex;
  logic             nz_above;
  logic             lz_hide;
  logic             hide_blink;
  logic             vis;
  logic             drive;
  logic             lit;
  logic [6:0]       seg_d;
  logic [N_DIG-1:0] an_d;
  logic             dp_d;
  logic             unused_ok;

  assign tick     = (slot_q == SLOT_LAST);
  assign commit   = tick && (idx_q == IDX_LAST);
  assign idx_w    = 4'(idx_q);
  assign hex_base = 6'({idx_q, 2'b00});

  always_comb begin
    ld_set = '0;
    ld_set.digits[4*N_DIG-1:0] = digits;
    ld_set.dp[N_DIG-1:0]       = dp_in;
    ld_set.blank[N_DIG-1:0]    = blank;
`ifdef SEVENSEG_BLINK_EN
    ld_set.blink_mask[N_DIG-1:0] = blink_mask;
`endif
    ld_set.lz_en = lz_en;
  end

`ifdef SEVENSEG_BLINK_EN
  logic [BLINK_W-1:0] blink_q;

  always_ff @(posedge clk) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_q + BLINK_W'(1);
  end

  assign hide_blink = blink_q[BLINK_W-1] && act_q.blink_mask[idx_w];
`else
  assign hide_blink = 1'b0;
`endif

  // Leading zeros: this digit and every more-significant one are zero.
  always_comb begin
    nz_above = 1'b0;
    for (int j = 0; j < N_DIG; j++) begin
      if (j >= int'(idx_q) && act_q.digits[4*j +: 4] != 4'd0)
        nz_above = 1'b1;
    end
  end

  assign cur_hex = act_q.digits[hex_base +: 4];
  assign lz_hide = act_q.lz_en && (idx_q != '0) && !nz_above;
  assign vis     = !act_q.blank[idx_w] && !lz_hide && !hide_blink;
  assign drive   = (&bright_q) || (pwm_q < bright_q);
  assign lit     = vis && drive;

  sevenseg_dec u_dec (
    .hex_i (cur_hex),
    .en_i  (lit),
    .seg_o (seg_d)
  );

  assign an_d = lit ? ~(N_DIG'(1) << idx_q) : {N_DIG{AN_OFF}};
  assign dp_d = lit ? ~act_q.dp[idx_w] : DP_OFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      idx_q    <= '0;
      pwm_q    <= '0;
      bright_q <= '0;
      pend_q   <= '0;
      act_q    <= '0;
      upd_q    <= 1'b0;
      frame_q  <= 1'b0;
      seg_q    <= SEG_BLANK;
      an_q     <= {N_DIG{AN_OFF}};
      dp_q     <= DP_OFF;
    end else begin
      pwm_q   <= pwm_q + BRIGHT_W'(1);
      slot_q  <= tick ? '0 : slot_q + SW'(1);
      frame_q <= commit;
      if (tick) begin
        idx_q    <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        bright_q <= bright;
      end
      if (load)
        pend_q <= ld_set;
      // A load landing on the commit edge bypasses the pending set.
      if (commit) begin
        act_q <= load ? ld_set : pend_q;
        upd_q <= 1'b0;
      end else if (load) begin
        upd_q <= 1'b1;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign unused_ok = ^{blink_mask, act_q, AN_ON};

  assign upd_pend = upd_q;
  assign frame    = frame_q;
  assign seg      = seg_q;
  assign an       = an_q;
  assign dp       = dp_q;

endmodule
